// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode.
// Holds up to DEPTH {instr, pc, pre_pc} entries. The oldest entry is
// presented to decode with a valid/ready handshake. A flush discards all
// buffered entries and any push in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_queue_i_valid,
    input  logic [31:0]      fetch_queue_i_instr,
    input  logic [63:0]      fetch_queue_i_pc,
    input  logic [63:0]      fetch_queue_i_pre_pc,
    input  logic             fetch_queue_i_flush,
    input  logic             fetch_queue_i_decode_ready,
    output logic             fetch_queue_o_ready,
    output logic             fetch_queue_o_valid,
    output logic [31:0]      fetch_queue_o_instr,
    output logic [63:0]      fetch_queue_o_pc,
    output logic [63:0]      fetch_queue_o_pre_pc,
    output logic [CNT_W-1:0] fetch_queue_o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pre_pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    entry_t           head;

    // ready/valid come straight from the registered count, so a pop in the
    // same cycle never opens a slot for a push into a full queue.
    assign fetch_queue_o_ready = (count != CNT_W'(DEPTH));
    assign fetch_queue_o_valid = (count != '0);
    assign fetch_queue_o_count = count;

    assign push = fetch_queue_i_valid & fetch_queue_o_ready & ~fetch_queue_i_flush;
    assign pop  = fetch_queue_o_valid & fetch_queue_i_decode_ready & ~fetch_queue_i_flush;

    // Entry storage; intentionally not reset, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr:  fetch_queue_i_instr,
                             pc:     fetch_queue_i_pc,
                             pre_pc: fetch_queue_i_pre_pc};
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fetch_queue_i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head mux; outputs read as zero while the queue is empty.
    always_comb begin
        head = '0;
        if (fetch_queue_o_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign fetch_queue_o_instr  = head.instr;
    assign fetch_queue_o_pc     = head.pc;
    assign fetch_queue_o_pre_pc = head.pre_pc;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Captures each fetched instruction with its PC and predicted next PC, buffers up to DEPTH entries in program order, and presents the oldest entry to decode through a valid/ready handshake. It decouples decode stalls from fetch and discards all buffered work on a pipeline redirect (flush).

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- fetch_queue_i_valid  input  1  fetch presents an instruction this cycle
- fetch_queue_i_instr  input  32  fetched instruction word
- fetch_queue_i_pc  input  64  PC of the fetched instruction
- fetch_queue_i_pre_pc  input  64  predicted next PC
- fetch_queue_i_flush  input  1  redirect; discard all entries and any same-cycle push
- fetch_queue_i_decode_ready  input  1  decode accepts the head entry this cycle
- fetch_queue_o_ready  output  1  queue can accept a push (not full)
- fetch_queue_o_valid  output  1  head entry is valid (not empty)
- fetch_queue_o_instr  output  32  head instruction
- fetch_queue_o_pc  output  64  head PC
- fetch_queue_o_pre_pc  output  64  head predicted next PC
- fetch_queue_o_count  output  CNT_W  current occupancy, 0..DEPTH

## Operation

- Storage: DEPTH entries of {instr, pc, pre_pc} (160 bits); write pointer, read pointer, count.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; count distinguishes full from empty.
- push = fetch_queue_i_valid & fetch_queue_o_ready & ~fetch_queue_i_flush.
- pop = fetch_queue_o_valid & fetch_queue_i_decode_ready & ~fetch_queue_i_flush.
- fetch_queue_o_ready = (count != DEPTH). Depends only on registered state; a same-cycle pop does not make a full queue ready.
- fetch_queue_o_valid = (count != 0).
- Head outputs come from the entry at the read pointer when valid. When empty, instr/pc/pre_pc are driven to 0.
- Push: write the entry at the write pointer, then increment the write pointer.
- Pop: increment the read pointer.
- Push and pop in the same cycle: both pointers advance and count is unchanged. Legal at any non-full, non-empty occupancy.
- Push while empty: no bypass; the entry appears at the head the next cycle.
- Flush has priority over everything: pointers and count go to 0 and the same-cycle push is dropped. Storage contents are not cleared. Decode must ignore head outputs in the flush cycle.
- Count updates: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH or underflows.
- Push attempts while full (valid=1, ready=0) are ignored; fetch must hold its outputs.

## Timing

- Reset (async assert, synchronous-edge release): pointers=0, count=0, o_valid=0, o_ready=1, o_instr/o_pc/o_pre_pc=0, o_count=0. Storage is not reset.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Buffered entries are lost.
- Latency: a push in cycle N is visible at the head in cycle N+1 (empty queue). Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained.
- o_ready, o_valid and o_count are pure functions of registers, with no combinational path from inputs.
- Head data depends only on registers, via the read-pointer mux.
- The flush effect is visible the cycle after assertion: o_valid=0, o_ready=1, o_count=0.

## Test plan

- Reset then single push: after rst, push instr 0x00000013, pc 0x80000000, pre_pc 0x80000004. Next cycle o_valid=1 with those exact values and o_count=1. With decode_ready=1 the queue returns to o_valid=0, o_count=0 and outputs 0.
- Fill to full, DEPTH=4: push pc 0x80000000..0x8000000C with decode_ready=0. After the 4th push, o_ready=0 and o_count=4. A 5th push (pc 0x80000010) is ignored. Popping 4 times returns pcs 0x80000000, 0x80000004, 0x80000008, 0x8000000C in order.
- Wrap-around: sustain simultaneous push/pop at occupancy 2 for 20 cycles, pcs incrementing by 4. The head pc sequence is strictly +4 per pop with no gaps or duplicates, and o_count stays 2.
- Full plus pop same cycle: at count=4, decode_ready=1 and i_valid=1. The pop occurs, the push is rejected (o_ready was 0), and next cycle o_count=3 and o_ready=1.
- Flush with simultaneous push/pop: at count=3, assert flush with i_valid=1 and decode_ready=1. Next cycle o_count=0, o_valid=0, o_ready=1. The next push, pc 0x80001000, is the head one cycle later.
- Async reset mid-stream: assert rst between clock edges at count=2. Outputs go to reset values before the next edge. After release, the first push behaves as in scenario 1.
